// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default sizing, receiver
// state codes and the data-bit clamp applied when a frame starts.
package uart_pkg;

    localparam int UART_MAX_BITS_DEF   = 9;
    localparam int UART_OVERSAMPLE_DEF = 16;

    // Receiver states (plain constants so older tools and netlists agree on the encoding)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    // Requested data bits limited to 5..max_bits
    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int unsigned max_bits);
        logic [3:0] res;
        res = req;
        if (req < 4'd5) begin
            res = 4'd5;
        end else if (32'(req) > max_bits) begin
            res = 4'(max_bits);
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO holding tagged receive words. Pointers carry one extra
// wrap bit so full and empty are told apart by the difference alone.
// A write into a full FIFO only lands when a read retires the head in the
// same cycle; otherwise the caller sees full and treats the word as dropped.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level;
    logic             do_wr;
    logic             do_rd;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level == LW'(DEPTH));
    assign empty_o = (level == '0);
    assign level_o = level;

    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted writes and reads
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + LW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + LW'(1);
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the tail slot
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled mid-bit sampling, optional parity, one or
// two stop bits, per-word parity/framing tags and a receive FIFO.
// Optional feature: define UART_RX_BREAK_DETECT_EN to turn an all-zero frame
// with a low stop bit into a brk pulse instead of a pushed word.
// Handshake: a word leaves the FIFO on every clk edge where rd_valid_o and
// rd_ready_i are both high; rd_valid_o never drops until that happens.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int MAX_BITS   = UART_MAX_BITS_DEF,
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               clk_div_i,
    input  logic [3:0]                bits_per_word_i,
    input  logic                      parity_en_i,
    input  logic                      parity_odd_i,
    input  logic                      two_stop_bit_i,
    input  logic                      rx_i,
    output logic [MAX_BITS-1:0]       rd_data_o,
    output logic                      rd_perr_o,
    output logic                      rd_ferr_o,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic [$clog2(DEPTH):0]    fifo_level_o,
    output logic                      busy_o,
    output logic                      overrun_o,
    input  logic                      clr_overrun_i,
    output logic                      brk_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int FW = MAX_BITS + 2;
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Synchroniser and sample tick
    logic                sync1_q, sync2_q;
    logic                rx_s;
    logic [15:0]         div_q, div_d;
    logic                tick;

    // Frame state
    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          bit_q, bit_d;
    logic [3:0]          nbits_q, nbits_d;
    logic                pen_q, pen_d;
    logic                podd_q, podd_d;
    logic                two_q, two_d;
    logic [MAX_BITS-1:0] shreg_q, shreg_d;
    logic                pbit_q, pbit_d;
    logic                ferr_q, ferr_d;
    logic                armed_q, armed_d;

    // Completed word waiting to enter the FIFO
    logic                push_q, push_d;
    logic [FW-1:0]       word_q, word_d;
    logic                overrun_q, overrun_d;

    // Frame completion terms
    logic                done;
    logic                frame_err;
    logic                frame_perr;

    // FIFO interface
    logic [FW-1:0]       head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                drop;

    assign rx_s = sync2_q;
    assign tick = (div_q >= clk_div_i);
    assign div_d = tick ? 16'd0 : (div_q + 16'd1);

    assign frame_perr = pen_q & ((^shreg_q ^ pbit_q) != podd_q);

`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_q, brk_d;
    logic stop1_low;
    logic is_break;
    // In STOP2 the first stop sample has already been folded into ferr_q
    assign stop1_low = (state_q == ST_STOP2) ? ferr_q : ~rx_s;
    assign is_break  = (shreg_q == '0) & ~(pen_q & pbit_q) & stop1_low;
    assign brk_o     = brk_q;
`else
    assign brk_o = 1'b0;
`endif

    // Receiver next-state: bit timing, sampling and frame completion
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        nbits_d    = nbits_q;
        pen_d      = pen_q;
        podd_d     = podd_q;
        two_d      = two_q;
        shreg_d    = shreg_q;
        pbit_d     = pbit_q;
        ferr_d     = ferr_q;
        armed_d    = armed_q;
        push_d     = 1'b0;
        word_d     = word_q;
        done       = 1'b0;
        frame_err  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!armed_q) begin
                    // A held-low line after a bad frame must go high before a new start counts
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end
                end else if (tick && !rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    nbits_d = clamp_bits(bits_per_word_i, MAX_BITS);
                    pen_d   = parity_en_i;
                    podd_d  = parity_odd_i;
                    two_d   = two_stop_bit_i;
                    shreg_d = '0;
                    pbit_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d          = '0;
                        shreg_d[bit_q] = rx_s;
                        if (bit_q == (nbits_q - 4'd1)) begin
                            state_d = pen_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        pbit_d  = rx_s;
                        state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (two_q) begin
                            ferr_d  = ~rx_s;
                            state_d = ST_STOP2;
                        end else begin
                            done      = 1'b1;
                            frame_err = ~rx_s;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_STOP2: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        done      = 1'b1;
                        frame_err = ferr_q | ~rx_s;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done) begin
            state_d = ST_IDLE;
            if (frame_err) begin
                armed_d = 1'b0;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            if (is_break) begin
                brk_d = 1'b1;
            end else begin
                push_d = 1'b1;
                word_d = {frame_err, frame_perr, shreg_q};
            end
`else
            push_d = 1'b1;
            word_d = {frame_err, frame_perr, shreg_q};
`endif
        end
    end

    // Synchroniser, tick divider and receiver registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            div_q   <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            nbits_q <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            two_q   <= 1'b0;
            shreg_q <= '0;
            pbit_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b1;
            push_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            div_q   <= div_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            nbits_q <= nbits_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            two_q   <= two_d;
            shreg_q <= shreg_d;
            pbit_q  <= pbit_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            push_q  <= push_d;
            word_q  <= word_d;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    // Break pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
        end
    end
`endif

    assign pop       = rd_valid_o & rd_ready_i;
    assign drop      = push_q & fifo_full & ~pop;
    // A fresh drop wins over a clear arriving in the same cycle
    assign overrun_d = (overrun_q & ~clr_overrun_i) | drop;

    // Sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push_q),
        .wr_data_i (word_q),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level_o)
    );

    // Head word is masked while empty so the outputs read 0 after reset
    assign {rd_ferr_o, rd_perr_o, rd_data_o} = fifo_empty ? '0 : head;
    assign rd_valid_o = ~fifo_empty;
    assign busy_o     = (state_q != ST_IDLE);
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (default build, break detect off).
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clk_div;
    logic [3:0]  bits_per_word;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop_bit;
    logic        rx;
    logic [8:0]  rd_data;
    logic        rd_perr;
    logic        rd_ferr;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  fifo_level;
    logic        busy;
    logic        overrun;
    logic        clr_overrun;
    logic        brk;

    int n_checks = 0;
    int n_fail   = 0;
    logic        rand_on = 1'b0;
    logic [10:0] exp_q[$];

    uart_rx_fifo dut (
        .clk             (clk),
        .rst             (rst),
        .clk_div_i       (clk_div),
        .bits_per_word_i (bits_per_word),
        .parity_en_i     (parity_en),
        .parity_odd_i    (parity_odd),
        .two_stop_bit_i  (two_stop_bit),
        .rx_i            (rx),
        .rd_data_o       (rd_data),
        .rd_perr_o       (rd_perr),
        .rd_ferr_o       (rd_ferr),
        .rd_valid_o      (rd_valid),
        .rd_ready_i      (rd_ready),
        .fifo_level_o    (fifo_level),
        .busy_o          (busy),
        .overrun_o       (overrun),
        .clr_overrun_i   (clr_overrun),
        .brk_o           (brk)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        logic [3:0] bpw;
        int         nsend;
        logic       pen;
        logic       podd;
        logic       pbit;
        logic       two;
        logic       stop_val;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one frame at the current clk_div, then one idle bit period.
    // tail_low keeps the line low for that many extra bit periods after the stop bits.
    task automatic send_frame(input logic [8:0] d, input int nb, input logic pen, input logic pbit,
                              input logic two, input logic stop_val, input int tail_low);
        int bc;
        bc = 16 * (int'(clk_div) + 1);
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (bc) @(negedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (bc) @(negedge clk);
        end
        rx = stop_val;
        repeat (bc) @(negedge clk);
        if (two) begin
            rx = 1'b1;
            repeat (bc) @(negedge clk);
        end
        if (tail_low > 0) begin
            rx = 1'b0;
            repeat (tail_low * bc) @(negedge clk);
        end
        rx = 1'b1;
        repeat (bc) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [3:0] bpw, input logic pen, input logic podd, input logic two);
        bits_per_word = bpw;
        parity_en     = pen;
        parity_odd    = podd;
        two_stop_bit  = two;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!rd_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, rd_valid}, 32'd1);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    // Random-phase consumer: random rd_ready, every popped head compared with the model queue
    always @(negedge clk) begin
        if (rand_on) begin
            logic take;
            take = ($urandom_range(0, 1) == 1);
            if (rd_valid && take) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_word", {21'd0, rd_ferr, rd_perr, rd_data}, 32'h7ff);
                end else begin
                    check("rand_word", {21'd0, rd_ferr, rd_perr, rd_data}, {21'd0, exp_q.pop_front()});
                end
            end
            rd_ready = take;
        end
    end

    initial begin
        // Directed frame table: {stimulus, expected head word}
        vecs[0] = '{9'h0A5, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{9'h1FF, 4'd9,  9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b1, 1'b0};
        vecs[2] = '{9'h1FF, 4'd9,  9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0};
        vecs[3] = '{9'h03C, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1};
        vecs[4] = '{9'h01A, 4'd3,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h01A, 1'b0, 1'b0};
        vecs[5] = '{9'h155, 4'd15, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h155, 1'b0, 1'b0};
        vecs[6] = '{9'h041, 4'd7,  7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'h041, 1'b0, 1'b0};
        vecs[7] = '{9'h041, 4'd7,  7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h041, 1'b1, 1'b0};
        vecs[8] = '{9'h02A, 4'd6,  6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 9'h02A, 1'b0, 1'b1};
        vecs[9] = '{9'h1FF, 4'd5,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h01F, 1'b0, 1'b0};

        // Reset
        rst = 1'b1;
        clk_div = 16'd0;
        rx = 1'b1;
        rd_ready = 1'b0;
        clr_overrun = 1'b0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid",   {31'd0, rd_valid}, 32'd0);
        check("reset_level",   {27'd0, fifo_level}, 32'd0);
        check("reset_busy",    {31'd0, busy}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_head",    {21'd0, rd_ferr, rd_perr, rd_data}, 32'd0);
        check("reset_brk",     {31'd0, brk}, 32'd0);

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            set_cfg(vecs[i].bpw, vecs[i].pen, vecs[i].podd, vecs[i].two);
            send_frame(vecs[i].data, vecs[i].nsend, vecs[i].pen, vecs[i].pbit,
                       vecs[i].two, vecs[i].stop_val, 0);
            wait_valid("vec_valid", 100);
            check("vec_data",  {23'd0, rd_data}, {23'd0, vecs[i].exp_data});
            check("vec_perr",  {31'd0, rd_perr}, {31'd0, vecs[i].exp_perr});
            check("vec_ferr",  {31'd0, rd_ferr}, {31'd0, vecs[i].exp_ferr});
            check("vec_level", {27'd0, fifo_level}, 32'd1);
            pop_one();
            check("vec_level_after_pop", {27'd0, fifo_level}, 32'd0);
        end

        // Word becomes visible shortly after the receiver goes idle
        begin
            int k;
            set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
            fork
                send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
                begin
                    k = 0;
                    while (!busy && k < 400) begin @(negedge clk); k++; end
                    while (busy && k < 400) begin @(negedge clk); k++; end
                    k = 0;
                    while (!rd_valid && k < 10) begin @(negedge clk); k++; end
                    check("valid_soon_after_idle", {31'd0, (k <= 3)}, 32'd1);
                end
            join
            check("valid_word", {23'd0, rd_data}, 32'h05A);
            pop_one();
        end

        // Framing error followed by a long low line: exactly one word
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 40);
        repeat (100) @(negedge clk);
        check("held_low_level", {27'd0, fifo_level}, 32'd1);
        check("held_low_data",  {23'd0, rd_data}, 32'h03C);
        check("held_low_ferr",  {31'd0, rd_ferr}, 32'd1);
        pop_one();

        // Short low glitch from idle
        begin
            int busy_cnt;
            busy_cnt = 0;
            rx = 1'b0;
            repeat (4) @(negedge clk);
            rx = 1'b1;
            repeat (60) begin
                @(negedge clk);
                if (busy) busy_cnt++;
            end
            check("glitch_busy_seen",  {31'd0, (busy_cnt > 0)}, 32'd1);
            check("glitch_busy_short", {31'd0, (busy_cnt <= 16)}, 32'd1);
            check("glitch_busy_end",   {31'd0, busy}, 32'd0);
            check("glitch_level",      {27'd0, fifo_level}, 32'd0);
        end

        // Overflow: 17 words with no reads, the last one is lost
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            send_frame(9'(i * 7 + 3), 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        end
        check("ovf_level",   {27'd0, fifo_level}, 32'd16);
        check("ovf_overrun", {31'd0, overrun}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("ovf_order", {23'd0, rd_data}, 32'(i * 7 + 3));
            pop_one();
        end
        check("ovf_empty",  {27'd0, fifo_level}, 32'd0);
        check("ovf_sticky", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovf_cleared", {31'd0, overrun}, 32'd0);

        // Full FIFO with a read on the push cycle: nothing lost
        for (int i = 0; i < 16; i++) begin
            send_frame(9'(8'h41 + i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        end
        check("full_level", {27'd0, fifo_level}, 32'd16);
        fork
            send_frame(9'h080, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
            begin
                int k;
                k = 0;
                while (!busy && k < 400) begin @(negedge clk); k++; end
                while (busy && k < 400) begin @(negedge clk); k++; end
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
            end
        join
        check("full_pp_level",   {27'd0, fifo_level}, 32'd16);
        check("full_pp_overrun", {31'd0, overrun}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            check("full_pp_order", {23'd0, rd_data}, 32'(8'h41 + i));
            pop_one();
        end
        check("full_pp_last", {23'd0, rd_data}, 32'h080);
        pop_one();
        check("full_pp_empty", {27'd0, fifo_level}, 32'd0);

        // Reset in the middle of the data bits
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("rst_pre_level", {27'd0, fifo_level}, 32'd1);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        rx = 1'b0;
        repeat (24) @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        check("rst_mid_busy",  {31'd0, busy}, 32'd0);
        check("rst_mid_level", {27'd0, fifo_level}, 32'd0);
        check("rst_mid_valid", {31'd0, rd_valid}, 32'd0);
        repeat (300) @(negedge clk);
        check("rst_no_partial", {27'd0, fifo_level}, 32'd0);

        // Randomised frames against the reference model
        rand_on = 1'b1;
        for (int n = 0; n < 24; n++) begin
            int         nb;
            logic [8:0] d;
            logic [3:0] bpw;
            logic       pen, podd, pbit, two, sv, perr_e;
            clk_div = 16'($urandom_range(0, 2));
            bpw     = 4'($urandom_range(0, 15));
            nb      = (bpw < 4'd5) ? 5 : ((bpw > 4'd9) ? 9 : int'(bpw));
            d       = 9'($urandom) & 9'((1 << nb) - 1);
            pen     = 1'($urandom);
            podd    = 1'($urandom);
            pbit    = 1'($urandom);
            two     = 1'($urandom);
            sv      = ($urandom_range(0, 7) != 0);
            if (!sv && d == 9'd0) d = 9'd1;
            perr_e  = pen && ((($countones(d) + int'(pbit)) % 2) != int'(podd));
            exp_q.push_back({~sv, perr_e, d});
            set_cfg(bpw, pen, podd, two);
            send_frame(d, nb, pen, pbit, two, sv, 0);
        end
        begin
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 3000) begin @(negedge clk); k++; end
        end
        rand_on = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rand_drained",   exp_q.size(), 32'd0);
        check("rand_level",     {27'd0, fifo_level}, 32'd0);
        check("rand_overrun",   {31'd0, overrun}, 32'd0);
        check("rand_brk",       {31'd0, brk}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time limit
    initial begin
        #3000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
